// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a two-entry skid buffer; in_ready decodes registered state only.
// Optional head-entry forwarding port compiled in with EX_MEM_SKID_FWD_EN.
module ex_mem_skid #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_out,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sd;
    logic [4:0]      rd;
    logic            we;
  } entry_t;

  state_t state, state_nx;
  entry_t head, skid, in_entry;
  logic   head_load_in, head_load_skid, skid_load;
  logic   in_xfer, out_xfer;

  assign in_ready  = (state != S_FULL);
  assign out_valid = (state != S_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Writes to x0 are neutralised once, at capture.
  assign in_entry.alu = in_alu_out;
  assign in_entry.sd  = in_store_data;
  assign in_entry.rd  = in_rd;
  assign in_entry.we  = in_rd_we & (in_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_xfer) begin
            state_nx     = S_ONE;
            head_load_in = 1'b1;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            head_load_in = 1'b1;
          end else if (in_xfer) begin
            state_nx  = S_FULL;
            skid_load = 1'b1;
          end else if (out_xfer) begin
            state_nx = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            state_nx       = S_ONE;
            head_load_skid = 1'b1;
          end
        end
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  // Data registers only move on a load, so fields hold while stalled or empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (head_load_in)        head <= in_entry;
      else if (head_load_skid) head <= skid;
      if (skid_load)           skid <= in_entry;
    end
  end

  assign out_alu_out    = head.alu;
  assign out_store_data = head.sd;
  assign out_rd         = head.rd;
  assign out_rd_we      = out_valid & head.we;

`ifdef EX_MEM_SKID_FWD_EN
  assign fwd_valid = out_valid & head.we;
  assign fwd_rd    = head.rd;
  assign fwd_data  = head.alu;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule
